// File: rtl/vga_rx_decoder.sv
// Sink-side VGA timing decoder: samples syncs and RGB, recovers active pixel
// coordinates, checks line/frame timing and declares lock after clean frames.
module vga_rx_decoder #(
  parameter int H_ACTIVE_VIDEO = 640,
  parameter int H_FRONT_PORCH  = 16,
  parameter int H_SYNC_PULSE   = 96,
  parameter int H_BACK_PORCH   = 48,
  parameter int V_ACTIVE_VIDEO = 480,
  parameter int V_FRONT_PORCH  = 11,
  parameter int V_SYNC_PULSE   = 2,
  parameter int V_BACK_PORCH   = 31,
  parameter int LOCK_FRAMES    = 2,
  localparam int POS_W = $clog2(H_ACTIVE_VIDEO) + 1
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             enable,
  input  logic             hsync,
  input  logic             vsync,
  input  logic             Rin,
  input  logic             Gin,
  input  logic             Bin,
  output logic             pixel_valid,
  output logic             Rout,
  output logic             Gout,
  output logic             Bout,
  output logic [POS_W-1:0] hpos,
  output logic [POS_W-1:0] vpos,
  output logic             frame_start,
  output logic             locked,
  output logic             timing_error,
  output logic [7:0]       err_count
);

  localparam int H_TOTAL = H_ACTIVE_VIDEO + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;
  localparam int V_TOTAL = V_ACTIVE_VIDEO + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;
  localparam int PH_W    = $clog2(2 * H_TOTAL + 1);
  localparam int LN_W    = $clog2(V_TOTAL + 1) + 1;
  localparam int GOOD_W  = $clog2(LOCK_FRAMES + 1);

  localparam logic [PH_W-1:0]   PH_MAX    = PH_W'(2 * H_TOTAL);
  localparam logic [PH_W-1:0]   H_LAST    = PH_W'(H_TOTAL - 1);
  localparam logic [PH_W-1:0]   H_RISE    = PH_W'(H_SYNC_PULSE);
  localparam logic [PH_W-1:0]   H_START   = PH_W'(H_SYNC_PULSE + H_BACK_PORCH);
  localparam logic [PH_W-1:0]   H_END     = PH_W'(H_SYNC_PULSE + H_BACK_PORCH + H_ACTIVE_VIDEO);
  localparam logic [LN_W-1:0]   LN_MAX    = '1;
  localparam logic [LN_W-1:0]   V_LAST    = LN_W'(V_TOTAL - 1);
  localparam logic [LN_W-1:0]   V_START   = LN_W'(V_SYNC_PULSE + V_BACK_PORCH);
  localparam logic [LN_W-1:0]   V_END     = LN_W'(V_SYNC_PULSE + V_BACK_PORCH + V_ACTIVE_VIDEO);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_FRAMES - 1);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  state_t             r_state;
  logic [GOOD_W-1:0]  r_good;
  logic               r_hs_q, r_vs_q, r_hs_d, r_vs_d;
  logic [2:0]         r_rgb_q;
  logic [PH_W-1:0]    r_h_phase;
  logic [LN_W-1:0]    r_v_line;
  logic               r_pixel_valid, r_frame_start, r_timing_error;
  logic [2:0]         r_rgb_out;
  logic [POS_W-1:0]   r_hpos, r_vpos;
  logic [7:0]         r_err_count;

  state_t             w_state_nxt;
  logic [GOOD_W-1:0]  w_good_nxt;
  logic               w_hfall, w_hrise, w_vfall;
  logic [PH_W-1:0]    w_h_phase;
  logic [LN_W-1:0]    w_v_line;
  logic               w_active, w_valid_nxt, w_err;
  logic [POS_W-1:0]   w_hpos, w_vpos;

  assign w_hfall = r_hs_d & ~r_hs_q;
  assign w_hrise = ~r_hs_d & r_hs_q;
  assign w_vfall = r_vs_d & ~r_vs_q;

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_h_phase = r_h_phase;
    if (w_hfall)                 w_h_phase = '0;
    else if (r_h_phase != PH_MAX) w_h_phase = r_h_phase + PH_W'(1);

    w_v_line = r_v_line;
    if (w_vfall)                         w_v_line = '0;
    else if (w_hfall && r_v_line != LN_MAX) w_v_line = r_v_line + LN_W'(1);
  end

  assign w_active = (w_h_phase >= H_START) && (w_h_phase < H_END) &&
                    (w_v_line >= V_START) && (w_v_line < V_END);
  assign w_hpos   = POS_W'(w_h_phase - H_START);
  assign w_vpos   = POS_W'(w_v_line - V_START);

  // Counters are unaligned in SEARCH, so that state (including the exit vfall) is never checked.
  assign w_err = (r_state != SEARCH) &&
                 ((w_hfall && r_h_phase != H_LAST) ||
                  (w_hrise && w_h_phase != H_RISE) ||
                  (w_vfall && r_v_line  != V_LAST) ||
                  (w_h_phase == PH_MAX && r_h_phase != PH_MAX));

  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good;
    case (r_state)
      SEARCH: if (w_vfall) begin
        w_state_nxt = VERIFY;
        w_good_nxt  = '0;
      end
      VERIFY: if (w_err) begin
        w_good_nxt = '0;
      end else if (w_vfall) begin
        if (r_good == GOOD_LAST) begin
          w_state_nxt = LOCKED;
          w_good_nxt  = '0;
        end else begin
          w_good_nxt = r_good + GOOD_W'(1);
        end
      end
      LOCKED: if (w_err) w_state_nxt = SEARCH;
      default: w_state_nxt = SEARCH;
    endcase
  end

  assign w_valid_nxt = w_active && (w_state_nxt == LOCKED);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state        <= SEARCH;
      r_good         <= '0;
      r_hs_q         <= 1'b1;
      r_vs_q         <= 1'b1;
      r_hs_d         <= 1'b1;
      r_vs_d         <= 1'b1;
      r_rgb_q        <= '0;
      r_h_phase      <= '0;
      r_v_line       <= '0;
      r_pixel_valid  <= 1'b0;
      r_frame_start  <= 1'b0;
      r_timing_error <= 1'b0;
      r_rgb_out      <= '0;
      r_hpos         <= '0;
      r_vpos         <= '0;
      r_err_count    <= '0;
    end else if (enable) begin
      r_state        <= w_state_nxt;
      r_good         <= w_good_nxt;
      r_hs_q         <= hsync;
      r_vs_q         <= vsync;
      r_hs_d         <= r_hs_q;
      r_vs_d         <= r_vs_q;
      r_rgb_q        <= {Rin, Gin, Bin};
      r_h_phase      <= w_h_phase;
      r_v_line       <= w_v_line;
      r_pixel_valid  <= w_valid_nxt;
      r_frame_start  <= w_valid_nxt && (w_hpos == '0) && (w_vpos == '0);
      r_timing_error <= w_err;
      r_rgb_out      <= w_valid_nxt ? r_rgb_q : 3'b000;
      if (w_valid_nxt) begin
        r_hpos <= w_hpos;
        r_vpos <= w_vpos;
      end
      if (w_err && r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
    end
  end

  // Pulse-type outputs are masked while the clock enable is low; their flops simply hold.
  assign pixel_valid  = r_pixel_valid & enable;
  assign frame_start  = r_frame_start & enable;
  assign timing_error = r_timing_error & enable;
  assign Rout         = r_rgb_out[2] & enable;
  assign Gout         = r_rgb_out[1] & enable;
  assign Bout         = r_rgb_out[0] & enable;
  assign hpos         = r_hpos;
  assign vpos         = r_vpos;
  assign locked       = (r_state == LOCKED);
  assign err_count    = r_err_count;

endmodule

// File: tb/tb_vga_rx_decoder.sv
// Self-checking bench for vga_rx_decoder using a scaled-down 15x8 raster
// (8x4 active) so that many full frames fit in a short run.
module tb_vga_rx_decoder;

  localparam int HA = 8, HFP = 2, HS = 3, HBP = 2;
  localparam int VA = 4, VFP = 1, VS = 2, VBP = 1;
  localparam int H_TOTAL = HA + HFP + HS + HBP;  // 15
  localparam int V_TOTAL = VA + VFP + VS + VBP;  // 8
  localparam int HOLD_LEN = 2 * H_TOTAL + 5;
  localparam int W = $clog2(HA) + 1;

  logic clk = 1'b0;
  logic nrst, enable, hsync, vsync, Rin, Gin, Bin;
  logic pixel_valid, Rout, Gout, Bout, frame_start, locked, timing_error;
  logic [W-1:0] hpos, vpos;
  logic [7:0] err_count;

  vga_rx_decoder #(
    .H_ACTIVE_VIDEO(HA), .H_FRONT_PORCH(HFP), .H_SYNC_PULSE(HS), .H_BACK_PORCH(HBP),
    .V_ACTIVE_VIDEO(VA), .V_FRONT_PORCH(VFP), .V_SYNC_PULSE(VS), .V_BACK_PORCH(VBP),
    .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .nrst(nrst), .enable(enable), .hsync(hsync), .vsync(vsync),
    .Rin(Rin), .Gin(Gin), .Bin(Bin), .pixel_valid(pixel_valid),
    .Rout(Rout), .Gout(Gout), .Bout(Bout), .hpos(hpos), .vpos(vpos),
    .frame_start(frame_start), .locked(locked), .timing_error(timing_error),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       act;
    logic [3:0] x;
    logic [3:0] y;
    logic [2:0] rgb;
  } pix_t;

  typedef struct {
    int frames;
    bit short_first;
    int stretch_line;
    int hold_line;
    bit pre_midline;
    bit exp_locked;
    int exp_err;
    int exp_valid;
    int exp_pulse;
    int exp_fs;
  } seg_t;

  int   n_checks = 0, n_fail = 0;
  int   n_valid, n_pulse, n_fs, hold_left;
  pix_t hist0, hist1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_valid"}, pixel_valid, 0);
    check({name, "_rgb"}, {Rout, Gout, Bout}, 0);
    check({name, "_pos"}, {hpos, vpos}, 0);
    check({name, "_flags"}, {frame_start, locked, timing_error}, 0);
    check({name, "_errcnt"}, err_count, 0);
  endtask

  // Outputs now reflect the pixel driven two cycles ago (hist1).
  task automatic monitor();
    if (pixel_valid) begin
      n_valid++;
      check("valid_in_active", hist1.act, 1);
      check("hpos", hpos, hist1.x);
      check("vpos", vpos, hist1.y);
      check("rgb", {Rout, Gout, Bout}, hist1.rgb);
      check("frame_start", frame_start, (hist1.x == 0 && hist1.y == 0));
    end else begin
      check("rgb_idle", {Rout, Gout, Bout}, 0);
      check("fs_idle", frame_start, 0);
    end
    if (timing_error) n_pulse++;
    if (frame_start) n_fs++;
  endtask

  task automatic drive_now(input int h, input int v, input bit hs_force);
    int x, y;
    logic [2:0] c;
    monitor();
    x = h - HS - HBP;
    y = v - VS - VBP;
    c = 3'(3 * x + 5 * y + 5);
    hsync = hs_force ? 1'b1 : (h >= HS);
    vsync = (v >= VS);
    {Rin, Gin, Bin} = c;
    hist1 = hist0;
    hist0 = '{act: (x >= 0 && x < HA && y >= 0 && y < VA), x: 4'(x), y: 4'(y), rgb: c};
  endtask

  task automatic drive(input int h, input int v, input bit hs_force);
    @(negedge clk);
    drive_now(h, v, hs_force);
  endtask

  task automatic run_frame(input int lines, input int stretch_line, input int hold_line);
    for (int v = 0; v < lines; v++) begin
      for (int h = 0; h < H_TOTAL; h++) begin
        if (v == hold_line && h == 0) hold_left = HOLD_LEN;
        drive(h, v, hold_left > 0);
        if (hold_left > 0) hold_left--;
        if (v == stretch_line && h == H_TOTAL - 1) drive(h, v, 1'b0);
      end
    end
  endtask

  // Partial frame while locked, an enable pause mid-line, then an async reset.
  task automatic midline_sequence();
    for (int v = 0; v < 4; v++)
      for (int h = 0; h < H_TOTAL; h++) drive(h, v, 1'b0);
    for (int h = 0; h < 10; h++) drive(h, 4, 1'b0);
    @(negedge clk);
    enable = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("freeze_hpos", hpos, 3);
      check("freeze_vpos", vpos, 1);
      check("freeze_pulses", {pixel_valid, frame_start, timing_error}, 0);
      @(negedge clk);
    end
    enable = 1'b1;
    #1;
    drive_now(10, 4, 1'b0);
    drive(11, 4, 1'b0);
    @(negedge clk);
    check("pre_reset_locked", locked, 1);
    check("pre_reset_errcnt", err_count, 2);
    #2 nrst = 1'b0;
    #1 check_all_zero("async_reset");
    @(posedge clk);
    #1 check_all_zero("held_reset");
    @(negedge clk);
    nrst = 1'b1;
  endtask

  seg_t segs[7];

  initial begin
    segs[0] = '{4, 0, -1, -1, 0, 1, 0, 64, 0, 2};  // ideal stream, lock on 3rd vfall
    segs[1] = '{1, 0,  1, -1, 0, 0, 1,  0, 1, 0};  // one 16-clock line
    segs[2] = '{3, 0, -1, -1, 0, 1, 1, 32, 0, 1};  // relock, no valids before it
    segs[3] = '{1, 0, -1,  1, 0, 0, 2,  0, 1, 0};  // hsync stuck high > 2 lines
    segs[4] = '{3, 0, -1, -1, 0, 1, 2, 32, 0, 1};  // relock in 3 frames
    segs[5] = '{2, 1, -1, -1, 1, 0, 1,  0, 1, 0};  // reset, then short frame in VERIFY
    segs[6] = '{2, 0, -1, -1, 0, 1, 1, 32, 0, 1};  // two more clean frames lock

    nrst = 1'b0; enable = 1'b1; hsync = 1'b1; vsync = 1'b1;
    {Rin, Gin, Bin} = 3'b111;
    hist0 = '0; hist1 = '0; hold_left = 0;
    #3 check_all_zero("reset");
    @(posedge clk);
    #1 check_all_zero("reset_clocked");
    @(negedge clk);
    nrst = 1'b1;

    for (int i = 0; i < 7; i++) begin
      if (segs[i].pre_midline) midline_sequence();
      n_valid = 0; n_pulse = 0; n_fs = 0;
      for (int f = 0; f < segs[i].frames; f++)
        run_frame((f == 0 && segs[i].short_first) ? V_TOTAL - 1 : V_TOTAL,
                  (f == 0) ? segs[i].stretch_line : -1,
                  (f == 0) ? segs[i].hold_line : -1);
      check($sformatf("seg%0d_locked", i), locked, segs[i].exp_locked);
      check($sformatf("seg%0d_err_count", i), err_count, segs[i].exp_err);
      check($sformatf("seg%0d_valids", i), n_valid, segs[i].exp_valid);
      check($sformatf("seg%0d_err_pulses", i), n_pulse, segs[i].exp_pulse);
      check($sformatf("seg%0d_frame_starts", i), n_fs, segs[i].exp_fs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
